sort_checker: RTL and testbench
===============================

Name: sort_checker

Overview:
- Downstream consumer of the sorter output stream (src_valid/src_sop/src_eop/src_data), connected to its own snk_* inputs.
- Checks each packet for framing, non-decreasing order and length limit.
- Reports per-packet results (length, min, max, error flags) and running packet and error counters.
- Used as the self-check and monitor stage in the sort datapath. It never applies backpressure.

Parameters:
- DATA_WIDTH, 8: width of snk_data and pkt_min/pkt_max.
- MAX_LENGTH, 16: maximum legal beats per packet. Must be ≥ 2.
- DESCENDING, 0: 0 = check non-decreasing order; 1 = check non-increasing order.
- CNT_WIDTH, 16: width of the pkt_count and err_count counters.

Ports:
- snk_clock  in  1  single clock; all logic on rising edge.
- snk_reset_n  in  1  asynchronous, active-low reset.
- snk_valid  in  1  beat qualifier.
- snk_sop  in  1  first beat of packet; meaningful only with snk_valid.
- snk_eop  in  1  last beat of packet; meaningful only with snk_valid.
- snk_data  in  DATA_WIDTH  beat data, compared as unsigned.
- clear  in  1  synchronous clear of pkt_count and err_count.
- pkt_done  out  1  one-cycle pulse; per-packet result outputs are updated in this cycle.
- pkt_ok  out  1  1 when no error flag is set for the packet.
- err_order  out  1  at least one order violation in the packet.
- err_framing  out  1  packet was terminated by a new sop instead of an eop.
- err_length  out  1  packet exceeded MAX_LENGTH beats.
- pkt_length  out  $clog2(MAX_LENGTH+1)  beats counted, saturating at MAX_LENGTH.
- pkt_min  out  DATA_WIDTH  smallest data value in the packet.
- pkt_max  out  DATA_WIDTH  largest data value in the packet.
- pkt_count  out  CNT_WIDTH  packets completed; saturating.
- err_count  out  CNT_WIDTH  errored packets plus orphan beats; saturating.

Behaviour:
- Reset: asserting snk_reset_n low asynchronously sets all outputs and internal state to 0 and the FSM to IDLE.
- Reset mid-packet: the partial packet is discarded and no pkt_done is produced.
- A beat is a clock edge with snk_valid=1. Cycles with snk_valid=0 leave all state unchanged; gaps are legal anywhere.
- Internal state: len, run_min, run_max, prev, and sticky flags for order and length errors.
- FSM IDLE, beat with sop:
  - Set len=1, run_min=run_max=prev=data, clear all sticky flags.
  - If eop is also set, finish the packet on this edge; otherwise go to BUSY.
- FSM IDLE, beat without sop (orphan):
  - Discard the data and increment err_count.
  - No pkt_done; stay in IDLE.
- FSM BUSY, beat without sop:
  - Order error: DESCENDING=0 and data < prev, or DESCENDING=1 and data > prev, sets the order flag. Equal values are legal.
  - Set prev=data and update run_min/run_max.
  - Length: if len==MAX_LENGTH, set the length flag and hold len; else len+1.
  - If eop: finish the packet and go to IDLE.
- FSM BUSY, beat with sop (framing error):
  - Finish the current packet with err_framing=1; the sop beat is not counted in it.
  - Start a new packet from the sop beat on the same edge, exactly as in IDLE, including an sop+eop single-beat finish.
  - The two finishes fall on consecutive edges; pkt_done pulses in two consecutive cycles.
- Finish:
  - On the edge after the finishing beat, pkt_done=1 for exactly one cycle. Latency from the eop beat is 1 cycle.
  - pkt_length, pkt_min, pkt_max, err_* and pkt_ok are registered on that same edge and held until the next pkt_done.
  - pkt_count increments.
  - err_count increments if any error flag is set.
  - An orphan beat in the same cycle adds 1 more to err_count.
- Counters: saturate at all-ones and never wrap.
- clear: zeroes both counters on the next edge and wins over any simultaneous increment. It does not affect the per-packet result outputs or the FSM.
- A beat with sop=eop=1 while in BUSY: framing finish for the old packet, then the single-beat finish for the new one.

Test Plan:
1. DATA_WIDTH=8; beats 3(sop),5,5,9(eop) → one pkt_done 1 cycle after the eop beat; pkt_ok=1, pkt_length=4, pkt_min=3, pkt_max=9, pkt_count=1, err_count=0.
2. Beats 4(sop),2,7(eop) → err_order=1, pkt_ok=0, pkt_min=2, pkt_max=7, err_count=1. Repeat with DESCENDING=1 and beats 9,9,1 → pkt_ok=1.
3. Single beat sop+eop, data 0x42 → pkt_length=1, pkt_min=pkt_max=0x42, pkt_ok=1. snk_valid gaps inserted between the beats of scenario 1 give identical results.
4. Beats 1(sop),2, then 6(sop),8(eop) → first pkt_done with err_framing=1, pkt_length=2; next cycle pkt_done with pkt_ok=1, pkt_length=2, pkt_min=6; pkt_count=2, err_count=1.
5. MAX_LENGTH=4; beats 1..6 ascending, sop on 1, eop on 6 → err_length=1, pkt_length=4, pkt_max=6. Separately, an orphan beat in IDLE → err_count+1 with no pkt_done.
6. clear asserted in the same cycle as a pkt_count increment → both counters read 0. snk_reset_n pulsed low after 2 beats of a packet → no pkt_done, all outputs 0, and the next clean packet reports correctly.

Source files
------------

// File: rtl/sort_checker.sv
// Packet monitor for the sorter output stream: checks framing, ordering and
// length of each packet and reports per-packet results plus running counters.
module sort_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 16,
  parameter int DESCENDING = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            snk_clock,
  input  logic                            snk_reset_n,
  input  logic                            snk_valid,
  input  logic                            snk_sop,
  input  logic                            snk_eop,
  input  logic [DATA_WIDTH-1:0]           snk_data,
  input  logic                            clear,
  output logic                            pkt_done,
  output logic                            pkt_ok,
  output logic                            err_order,
  output logic                            err_framing,
  output logic                            err_length,
  output logic [$clog2(MAX_LENGTH+1)-1:0] pkt_length,
  output logic [DATA_WIDTH-1:0]           pkt_min,
  output logic [DATA_WIDTH-1:0]           pkt_max,
  output logic [CNT_WIDTH-1:0]            pkt_count,
  output logic [CNT_WIDTH-1:0]            err_count
);
  localparam int LW = $clog2(MAX_LENGTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [LW-1:0]         len;
    logic [DATA_WIDTH-1:0] mn;
    logic [DATA_WIDTH-1:0] mx;
    logic                  ord;
    logic                  lng;
    logic                  frm;
  } res_t;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [DATA_WIDTH-1:0] min_q, min_d, max_q, max_d, prev_q, prev_d;
  logic                  ord_q, ord_d, lng_q, lng_d;
  logic                  pend_vld_q, pend_vld_d;
  res_t                  pend_q, res_q, res_a, res_b, res_out;
  logic                  done_q, ok_q;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, err_cnt_q;

  logic start, cont, orphan, viol, fin_a, fin_b, fin_any;
  logic [1:0] err_inc;

  assign start  = snk_valid & snk_sop;
  assign cont   = snk_valid & ~snk_sop & (state_q == BUSY);
  assign orphan = snk_valid & ~snk_sop & (state_q == IDLE);
  assign viol   = (DESCENDING != 0) ? (snk_data > prev_q) : (snk_data < prev_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    min_d   = min_q;
    max_d   = max_q;
    prev_d  = prev_q;
    ord_d   = ord_q;
    lng_d   = lng_q;
    if (start) begin
      len_d   = LW'(1);
      min_d   = snk_data;
      max_d   = snk_data;
      prev_d  = snk_data;
      ord_d   = 1'b0;
      lng_d   = 1'b0;
      state_d = snk_eop ? IDLE : BUSY;
    end else if (cont) begin
      ord_d  = ord_q | viol;
      prev_d = snk_data;
      if (snk_data < min_q) min_d = snk_data;
      if (snk_data > max_q) max_d = snk_data;
      if (len_q == LW'(MAX_LENGTH)) lng_d = 1'b1;
      else                          len_d = len_q + LW'(1);
      state_d = snk_eop ? IDLE : BUSY;
    end
  end

  // A sop inside a packet closes the old one (fin_a); a finish that collides
  // with an earlier one on the same edge is parked for one cycle.
  assign fin_a   = start & (state_q == BUSY);
  assign fin_b   = (start | cont) & snk_eop;
  assign fin_any = pend_vld_q | fin_a | fin_b;
  assign res_a   = '{len: len_q, mn: min_q, mx: max_q, ord: ord_q, lng: lng_q, frm: 1'b1};
  assign res_b   = '{len: len_d, mn: min_d, mx: max_d, ord: ord_d, lng: lng_d, frm: 1'b0};
  assign res_out = pend_vld_q ? pend_q : (fin_a ? res_a : res_b);
  assign pend_vld_d = (pend_vld_q | fin_a) & fin_b;
  assign err_inc = {1'b0, fin_any & (res_out.ord | res_out.lng | res_out.frm)} + {1'b0, orphan};

  always_ff @(posedge snk_clock or negedge snk_reset_n) begin
    if (!snk_reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      prev_q     <= '0;
      ord_q      <= 1'b0;
      lng_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      min_q      <= min_d;
      max_q      <= max_d;
      prev_q     <= prev_d;
      ord_q      <= ord_d;
      lng_q      <= lng_d;
      pend_vld_q <= pend_vld_d;
      if (pend_vld_d) pend_q <= res_b;
      done_q     <= fin_any;
      if (fin_any) begin
        res_q <= res_out;
        ok_q  <= ~(res_out.ord | res_out.lng | res_out.frm);
      end
      if (clear) begin
        pkt_cnt_q <= '0;
        err_cnt_q <= '0;
      end else begin
        pkt_cnt_q <= sat_add(pkt_cnt_q, {1'b0, fin_any});
        err_cnt_q <= sat_add(err_cnt_q, err_inc);
      end
    end
  end

  assign pkt_done    = done_q;
  assign pkt_ok      = ok_q;
  assign err_order   = res_q.ord;
  assign err_framing = res_q.frm;
  assign err_length  = res_q.lng;
  assign pkt_length  = res_q.len;
  assign pkt_min     = res_q.mn;
  assign pkt_max     = res_q.mx;
  assign pkt_count   = pkt_cnt_q;
  assign err_count   = err_cnt_q;
endmodule

// File: tb/tb_sort_checker.sv
// Directed bench for sort_checker: three instances (default, descending,
// MAX_LENGTH=4) share one input stream; each scenario checks the relevant one.
module tb_sort_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, sop = 1'b0, eop = 1'b0, clr = 1'b0;
  logic [7:0] data = '0;

  logic       a_done, a_ok, a_ord, a_frm, a_lng;
  logic [4:0] a_len;
  logic [7:0] a_min, a_max;
  logic [15:0] a_cnt, a_err;

  logic       b_done, b_ok, b_ord, b_frm, b_lng;
  logic [4:0] b_len;
  logic [7:0] b_min, b_max;
  logic [15:0] b_cnt, b_err;

  logic       c_done, c_ok, c_ord, c_frm, c_lng;
  logic [2:0] c_len;
  logic [7:0] c_min, c_max;
  logic [15:0] c_cnt, c_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sort_checker #(.DATA_WIDTH(8), .MAX_LENGTH(16), .DESCENDING(0), .CNT_WIDTH(16)) dut_a (
    .snk_clock(clk), .snk_reset_n(rst_n), .snk_valid(valid), .snk_sop(sop), .snk_eop(eop),
    .snk_data(data), .clear(clr), .pkt_done(a_done), .pkt_ok(a_ok), .err_order(a_ord),
    .err_framing(a_frm), .err_length(a_lng), .pkt_length(a_len), .pkt_min(a_min),
    .pkt_max(a_max), .pkt_count(a_cnt), .err_count(a_err));

  sort_checker #(.DATA_WIDTH(8), .MAX_LENGTH(16), .DESCENDING(1), .CNT_WIDTH(16)) dut_b (
    .snk_clock(clk), .snk_reset_n(rst_n), .snk_valid(valid), .snk_sop(sop), .snk_eop(eop),
    .snk_data(data), .clear(clr), .pkt_done(b_done), .pkt_ok(b_ok), .err_order(b_ord),
    .err_framing(b_frm), .err_length(b_lng), .pkt_length(b_len), .pkt_min(b_min),
    .pkt_max(b_max), .pkt_count(b_cnt), .err_count(b_err));

  sort_checker #(.DATA_WIDTH(8), .MAX_LENGTH(4), .DESCENDING(0), .CNT_WIDTH(16)) dut_c (
    .snk_clock(clk), .snk_reset_n(rst_n), .snk_valid(valid), .snk_sop(sop), .snk_eop(eop),
    .snk_data(data), .clear(clr), .pkt_done(c_done), .pkt_ok(c_ok), .err_order(c_ord),
    .err_framing(c_frm), .err_length(c_lng), .pkt_length(c_len), .pkt_min(c_min),
    .pkt_max(c_max), .pkt_count(c_cnt), .err_count(c_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat, sampled on the next rising edge; returns 1 ns after that edge.
  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    valid = 1'b1; sop = s; eop = e; data = d;
    @(posedge clk); #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_done", a_done, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_err", a_err, 0);
    chk("rst_len", a_len, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean ascending packet
    beat(8'd3, 1, 0);
    chk("s1_nodone", a_done, 0);
    beat(8'd5, 0, 0); beat(8'd5, 0, 0); beat(8'd9, 0, 1);
    chk("s1_done", a_done, 1);
    chk("s1_ok", a_ok, 1);
    chk("s1_len", a_len, 4);
    chk("s1_min", a_min, 3);
    chk("s1_max", a_max, 9);
    chk("s1_cnt", a_cnt, 1);
    chk("s1_err", a_err, 0);
    idle(1);
    chk("s1_pulse", a_done, 0);
    chk("s1_hold", a_len, 4);

    // Order violation, then descending checker on a non-increasing packet
    beat(8'd4, 1, 0); beat(8'd2, 0, 0); beat(8'd7, 0, 1);
    chk("s2_ord", a_ord, 1);
    chk("s2_ok", a_ok, 0);
    chk("s2_min", a_min, 2);
    chk("s2_max", a_max, 7);
    chk("s2_err", a_err, 1);
    beat(8'd9, 1, 0); beat(8'd9, 0, 0); beat(8'd1, 0, 1);
    chk("s2_desc_ok", b_ok, 1);
    chk("s2_desc_ord", b_ord, 0);
    chk("s2_desc_min", b_min, 1);
    chk("s2_asc_ord", a_ord, 1);

    // Single-beat packet, then scenario 1 with gaps
    beat(8'h42, 1, 1);
    chk("s3_done", a_done, 1);
    chk("s3_len", a_len, 1);
    chk("s3_min", a_min, 8'h42);
    chk("s3_max", a_max, 8'h42);
    chk("s3_ok", a_ok, 1);
    beat(8'd3, 1, 0); idle(2); beat(8'd5, 0, 0); idle(1);
    chk("s3_gap_nodone", a_done, 0);
    beat(8'd5, 0, 0); idle(3); beat(8'd9, 0, 1);
    chk("s3_gap_done", a_done, 1);
    chk("s3_gap_ok", a_ok, 1);
    chk("s3_gap_len", a_len, 4);
    chk("s3_gap_min", a_min, 3);
    chk("s3_gap_max", a_max, 9);
    chk("s3_cnt", a_cnt, 5);
    chk("s3_err", a_err, 2);

    // Framing error: new sop before eop
    pulse_clear();
    chk("clr_cnt", a_cnt, 0);
    chk("clr_err", a_err, 0);
    beat(8'd1, 1, 0); beat(8'd2, 0, 0); beat(8'd6, 1, 0);
    chk("s4_done1", a_done, 1);
    chk("s4_frm1", a_frm, 1);
    chk("s4_len1", a_len, 2);
    chk("s4_ok1", a_ok, 0);
    beat(8'd8, 0, 1);
    chk("s4_done2", a_done, 1);
    chk("s4_ok2", a_ok, 1);
    chk("s4_frm2", a_frm, 0);
    chk("s4_len2", a_len, 2);
    chk("s4_min2", a_min, 6);
    chk("s4_cnt", a_cnt, 2);
    chk("s4_err", a_err, 1);
    // sop+eop beat inside a packet: two back-to-back finishes
    beat(8'd1, 1, 0); beat(8'd5, 1, 1);
    chk("s4b_done1", a_done, 1);
    chk("s4b_frm1", a_frm, 1);
    chk("s4b_len1", a_len, 1);
    chk("s4b_min1", a_min, 1);
    idle(1);
    chk("s4b_done2", a_done, 1);
    chk("s4b_ok2", a_ok, 1);
    chk("s4b_min2", a_min, 5);
    chk("s4b_len2", a_len, 1);
    idle(1);
    chk("s4b_quiet", a_done, 0);
    chk("s4b_cnt", a_cnt, 4);
    chk("s4b_err", a_err, 2);

    // Length overflow with MAX_LENGTH=4, then an orphan beat
    pulse_clear();
    beat(8'd1, 1, 0);
    for (int i = 2; i <= 5; i++) beat(8'(i), 0, 0);
    beat(8'd6, 0, 1);
    chk("s5_done", c_done, 1);
    chk("s5_lng", c_lng, 1);
    chk("s5_len", c_len, 4);
    chk("s5_max", c_max, 6);
    chk("s5_ok", c_ok, 0);
    chk("s5_cerr", c_err, 1);
    chk("s5_alng", a_lng, 0);
    idle(1);
    beat(8'd7, 0, 0);
    chk("s5_orph_done", a_done, 0);
    chk("s5_orph_err", a_err, 1);
    chk("s5_orph_cnt", a_cnt, 1);

    // clear wins over a simultaneous increment
    beat(8'd3, 1, 0);
    clr = 1'b1;
    beat(8'd4, 0, 1);
    clr = 1'b0;
    chk("s6_clr_done", a_done, 1);
    chk("s6_clr_cnt", a_cnt, 0);
    chk("s6_clr_err", a_err, 0);
    chk("s6_clr_len", a_len, 2);

    // Reset mid-packet
    beat(8'd1, 1, 0); beat(8'd2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_done", a_done, 0);
    chk("s6_rst_len", a_len, 0);
    chk("s6_rst_max", a_max, 0);
    chk("s6_rst_ok", a_ok, 0);
    chk("s6_rst_cnt", a_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    beat(8'd3, 0, 1);
    chk("s6_post_nodone", a_done, 0);
    chk("s6_post_orph", a_err, 1);
    beat(8'd10, 1, 0); beat(8'd20, 0, 1);
    chk("s6_new_done", a_done, 1);
    chk("s6_new_ok", a_ok, 1);
    chk("s6_new_len", a_len, 2);
    chk("s6_new_min", a_min, 10);
    chk("s6_new_max", a_max, 20);
    chk("s6_new_cnt", a_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
